// File: rtl/lz_denorm_shifter_if.sv
// rtl/lz_denorm_shifter_if.sv - start/busy/done handshake bundle for the denormalizing shifter
//
// Signals:
//   start   request pulse, sampled only while the shifter is idle
//   din     32-bit word to denormalize
//   lz_cnt  requested leading-zero count (0..63, clamped to 32 by the shifter)
//   dout    shifted result, valid with done and held until the next accepted start
//   sticky  OR of every bit shifted out of the LSB, same validity as dout
//   busy    high from the cycle after an accepted start until done falls
//   done    single-cycle completion pulse
// Modports: master drives the request, slave (the shifter) drives the result.
interface lz_denorm_shifter_if;
  logic        start;
  logic [31:0] din;
  logic [5:0]  lz_cnt;
  logic [31:0] dout;
  logic        sticky;
  logic        busy;
  logic        done;

  modport master (
    output start, din, lz_cnt,
    input  dout, sticky, busy, done
  );

  modport slave (
    input  start, din, lz_cnt,
    output dout, sticky, busy, done
  );
endinterface

// File: rtl/lz_denorm_shifter.sv
// rtl/lz_denorm_shifter.sv - multi-cycle logical right shifter that restores leading zeros
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous reset, active-high; aborts any operation in flight
//   bus  lz_denorm_shifter_if.slave: start/din/lz_cnt in, dout/sticky/busy/done out
// Parameter:
//   STEP maximum shift distance applied per SHIFT cycle (1..32)
module lz_denorm_shifter #(
  parameter int STEP = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  lz_denorm_shifter_if.slave   bus
);

  localparam logic [5:0] STEP_W = 6'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] acc_q;
  logic [5:0]  rem_q;
  logic        stk_q;
  logic [31:0] dout_q;
  logic        sticky_q;
  logic        busy_q;
  logic        done_q;

  logic [5:0]  cnt_clamp;
  logic [5:0]  s_d;
  logic [31:0] acc_d;
  logic [5:0]  rem_d;
  logic        lost_d;

  assign cnt_clamp = (bus.lz_cnt > 6'd32) ? 6'd32 : bus.lz_cnt;

  // One shift step. A shift amount of 32 makes the mask all ones and the
  // shifted word zero, so a full-width step needs no special case.
  always_comb begin
    s_d    = (rem_q < STEP_W) ? rem_q : STEP_W;
    acc_d  = acc_q >> s_d;
    lost_d = |(acc_q & ~(32'hFFFF_FFFF << s_d));
    rem_d  = rem_q - s_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      stk_q    <= 1'b0;
      dout_q   <= '0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // The IDLE cycle right after DONE is where done is visible; it
          // also clears here unless a new start keeps busy asserted.
          done_q <= 1'b0;
          if (bus.start) begin
            acc_q   <= bus.din;
            rem_q   <= cnt_clamp;
            stk_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= (cnt_clamp == 6'd0) ? DONE : SHIFT;
          end else begin
            busy_q <= 1'b0;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          stk_q <= stk_q | lost_d;
          rem_q <= rem_d;
          if (rem_d == 6'd0) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q   <= 1'b1;
          dout_q   <= acc_q;
          sticky_q <= stk_q;
          busy_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.dout   = dout_q;
  assign bus.sticky = sticky_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_lz_denorm_shifter.sv
// tb/tb_lz_denorm_shifter.sv - directed self-checking bench for lz_denorm_shifter
module tb_lz_denorm_shifter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  lz_denorm_shifter_if bus ();

  lz_denorm_shifter #(.STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and returns right after the edge that raised done.
  task automatic run_op(input string tag, input logic [31:0] d, input logic [5:0] lz,
                        input logic [31:0] exp_dout, input logic exp_sticky, input int exp_lat);
    int lat;
    lat = 0;
    bus.start  = 1'b1;
    bus.din    = d;
    bus.lz_cnt = lz;
    tick();
    bus.start  = 1'b0;
    bus.din    = 32'hDEAD_BEEF;
    bus.lz_cnt = 6'd63;
    check({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " dout"}, bus.dout, exp_dout);
    check({tag, " sticky"}, 32'(bus.sticky), 32'(exp_sticky));
    check({tag, " busy_in_done"}, 32'(bus.busy), 32'd1);
  endtask

  initial begin
    int ndone;
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.din    = '0;
    bus.lz_cnt = '0;
    #1;
    check("reset dout", bus.dout, 32'h0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset sticky", 32'(bus.sticky), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single shift step.
    run_op("t1", 32'h8000_0000, 6'd4, 32'h0800_0000, 1'b0, 2);
    tick();
    check("t1 done_falls", 32'(bus.done), 32'd0);
    check("t1 busy_falls", 32'(bus.busy), 32'd0);
    tick();
    check("t1 dout_held", bus.dout, 32'h0800_0000);

    // Partial last step (4 then 1), sticky from the low bit.
    run_op("t2", 32'hF000_0001, 6'd5, 32'h0780_0000, 1'b1, 3);
    tick();

    // Zero count goes straight to DONE, then an immediate back-to-back start.
    run_op("t3", 32'h1234_5678, 6'd0, 32'h1234_5678, 1'b0, 1);
    run_op("t3b", 32'h8000_0000, 6'd4, 32'h0800_0000, 1'b0, 2);
    tick();

    // Count clamp to 32 and full-width shift.
    run_op("t4", 32'h0000_0001, 6'd40, 32'h0000_0000, 1'b1, 9);
    tick();
    run_op("t4b", 32'hFFFF_FFFF, 6'd32, 32'h0000_0000, 1'b1, 9);
    tick();

    // Start pulsed again during SHIFT must be ignored.
    bus.start  = 1'b1;
    bus.din    = 32'hFFFF_FFFF;
    bus.lz_cnt = 6'd20;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start  = 1'b1;
    bus.din    = 32'h0000_0000;
    bus.lz_cnt = 6'd0;
    tick();
    bus.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done === 1'b1) begin
        ndone++;
        check("t5 dout", bus.dout, 32'h0000_0FFF);
        check("t5 sticky", 32'(bus.sticky), 32'd1);
      end
      tick();
    end
    check("t5 done_count", 32'(ndone), 32'd1);

    // Asynchronous reset in the second SHIFT cycle.
    bus.start  = 1'b1;
    bus.din    = 32'hFFFF_0000;
    bus.lz_cnt = 6'd16;
    tick();
    bus.start = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("t6 rst_dout", bus.dout, 32'h0);
    check("t6 rst_sticky", 32'(bus.sticky), 32'd0);
    check("t6 rst_busy", 32'(bus.busy), 32'd0);
    check("t6 rst_done", 32'(bus.done), 32'd0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1) ndone++;
    end
    check("t6 no_done_after_reset", 32'(ndone), 32'd0);
    run_op("t6b", 32'hF000_0001, 6'd5, 32'h0780_0000, 1'b1, 3);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lz_denorm_shifter.md
Name: lz_denorm_shifter

Overview:
- Multi-cycle denormalizer; the inverse direction of the CPU's leading-zero count path.
- Takes a normalized word and a leading-zero count, and logically right-shifts the word by that count. The result regains exactly that many leading zeros when din[31]=1.
- Sits beside the ALU's count path, on the execute stage. Driven by a start/busy/done handshake; the pipeline stalls while busy.
- Shifts at most STEP bits per cycle to keep the critical path short.

Parameters:
- STEP, 4, maximum shift distance per SHIFT cycle. Legal values: 1..32.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- din  in  32  word to denormalize.
- lz_cnt  in  6  requested leading-zero count, 0..63; values above 32 are clamped to 32.
- dout  out  32  shifted result; valid when done=1, held until the next accepted start.
- sticky  out  1  OR of all bits shifted out of the LSB; same validity as dout.
- busy  out  1  high from the cycle after an accepted start until done falls.
- done  out  1  single-cycle completion pulse.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; acc, rem, dout, sticky, busy, done all 0.
  - Any in-flight operation is aborted; no done is produced for it.
- Internal registers:
  - acc[31:0]: working word.
  - rem[5:0]: shift distance still to apply.
  - stk: sticky accumulator.
- IDLE:
  - On start=1: acc<=din; rem<=min(lz_cnt,32); stk<=0; busy<=1.
  - Next state is SHIFT if the clamped count is nonzero, else DONE.
  - start=0: stay in IDLE; outputs hold their previous values.
- SHIFT, each cycle:
  - s=min(rem,STEP); acc<=acc>>s (zero fill); stk<=stk | (|acc[s-1:0]); rem<=rem-s.
  - When rem-s==0, go to DONE; otherwise stay in SHIFT.
  - A 32-bit shift of the full word is legal and yields acc=0.
- DONE, one cycle:
  - done=1, dout=acc, sticky=stk, busy=1. Next state is IDLE.
  - busy falls and done falls on the following edge.
- Latency, with start accepted at edge T:
  - done is high during the cycle after edge T+1+ceil(n/STEP), where n is the clamped count.
  - n=0 gives done after edge T+1.
- Ignored inputs:
  - start in SHIFT or DONE is ignored (no queueing).
  - din and lz_cnt are sampled only at acceptance; later changes have no effect.
- Back-to-back operation:
  - start may be reasserted in the IDLE cycle immediately after DONE.
  - Minimum initiation interval is 2 cycles (n=0).
- dout and sticky update only in DONE; between operations they hold the last result.
- Width rule: rem is 6-bit, never exceeds 32, and cannot underflow because s<=rem.

Test Plan:
1. STEP=4, din=32'h8000_0000, lz_cnt=4 → one SHIFT cycle; dout=32'h0800_0000, sticky=0, done after edge T+2.
2. STEP=4, din=32'hF000_0001, lz_cnt=5 → two SHIFT cycles (4 then 1); dout=32'h0780_0000, sticky=1, done after edge T+3.
3. lz_cnt=0, din=32'h1234_5678 → no SHIFT cycles; dout=32'h1234_5678, sticky=0, done after edge T+1.
4. STEP=4, din=32'h0000_0001, lz_cnt=40 → clamped to 32, eight SHIFT cycles; dout=0, sticky=1, done after edge T+9.
5. Start accepted with lz_cnt=20, then start pulsed again with new din during SHIFT → second request ignored; exactly one done, carrying the first request's result.
6. Reset asserted in the 2nd SHIFT cycle → all outputs 0 immediately (asynchronous); no done after release; a fresh start then completes normally.
